risc_sequencer: RTL and testbench
=================================

# risc_sequencer

Program sequencer that drives the instruction inputs of the `RISC` core (`opcode`, `operand_1`, `operand_2`). It holds a 16-entry instruction store and, after `start`, fetches each instruction and resolves the sequencing opcodes (HALT, JMP) itself. Every other instruction is presented to the core for a fixed number of cycles so the core's registered decoder/RAM/ALU path completes. The sequencer sits between a host/testbench load port and the core, and is the core's only instruction source.

## Interface
Parameters:
- `ISSUE_CYCLES`, default 2: cycles each core instruction is held on the outputs; legal range 1–15.
- `NOP_OP`, default 4'h0: opcode driven whenever no instruction is issued. The core treats it as no-operation.
- `HALT_OP`, default 4'hF: sequencer-internal halt opcode; never issued to the core.
- `JMP_OP`, default 4'hE: sequencer-internal jump opcode; never issued to the core.

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `load_en` in 1: writes `load_data` into `prog_mem[load_addr]`; honoured only in IDLE or DONE.
- `load_addr` in 4: program store write address.
- `load_data` in 16: instruction word; [15:12] opcode, [11:8] operand_1, [7:0] operand_2.
- `start` in 1: begin execution at address 0; honoured only in IDLE or DONE.
- `abort` in 1: force return to IDLE from any state.
- `opcode` out 4: to core `opcode`.
- `operand_1` out 4: to core `operand_1`.
- `operand_2` out 8: to core `operand_2`.
- `issue_valid` out 1: high while a real instruction is on the outputs.
- `pc` out 4: address of the instruction being fetched or issued.
- `busy` out 1: high in FETCH, DECODE, ISSUE.
- `done` out 1: high in DONE (HALT reached).

## Operation
- Program store is 16×16, written only via the load port. Contents survive `rst` and are not cleared.
- States and transitions:
  - IDLE: `start` → FETCH, with pc=0.
  - FETCH: `ir <= prog_mem[pc]` → DECODE.
  - DECODE, on `ir[15:12]`:
    - HALT_OP → DONE.
    - JMP_OP → `pc <= ir[3:0]` → FETCH. `ir[11:4]` is ignored.
    - any other opcode → ISSUE, with `cnt <= ISSUE_CYCLES-1`.
  - ISSUE: drive `ir` onto the outputs with `issue_valid`=1. At cnt=0 → FETCH with `pc <= pc+1` (mod 16, so 15 wraps to 0). Otherwise `cnt <= cnt-1`.
  - DONE: `start` → FETCH with pc=0, and `done` clears.
- Outside ISSUE: `opcode`=NOP_OP, `operand_1`=0, `operand_2`=0, `issue_valid`=0.
- Priority, highest first: `rst` > `abort` > `start` > `load_en`.
  - `start` and `load_en` in the same IDLE/DONE cycle: the write completes and execution starts. The first fetch, one cycle later, sees the new word.
  - `load_en` in FETCH, DECODE or ISSUE is ignored; memory is unchanged.
  - `abort` → IDLE next cycle, pc=0, outputs return to NOP. An instruction mid-issue is cut short; the core sees NOP from the next cycle.
- A program without HALT loops indefinitely through the 16-entry store. This is legal, not an error.
- A jump to itself (JMP to own address) spins FETCH/DECODE with no issue. This is legal.

## Timing
- Reset values: state=IDLE, pc=0, `ir`=0, `cnt`=0, `opcode`=NOP_OP, `operand_1`=0, `operand_2`=0, `issue_valid`=0, `busy`=0, `done`=0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- `start` sampled at edge N:
  - FETCH during cycle N+1.
  - DECODE during N+2.
  - first ISSUE cycle during N+3.
- Per issued instruction: 2 + ISSUE_CYCLES cycles (FETCH, DECODE, ISSUE×ISSUE_CYCLES).
- Per JMP: 2 cycles.
- HALT: DONE is entered 2 cycles after HALT's FETCH begins; `done` rises with it.
- `issue_valid` stays continuously high for exactly ISSUE_CYCLES cycles per instruction. There is always ≥2 cycles of NOP between consecutive issues.
- `rst` asserted mid-ISSUE: next cycle all outputs are at reset values. The program store is retained.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst` for 2 cycles, then idle 5 cycles.
  - Required: `opcode`=NOP_OP, operands 0, `busy`=`done`=`issue_valid`=0, `pc`=0 throughout.
- Straight-line program, ISSUE_CYCLES=2:
  - Stimulus: load {16'h1234, 16'h25FF, 16'hF000}, then pulse `start`.
  - Required: 0x1/0x2/0x34 is held for 2 cycles starting 3 cycles after `start`; then 0x2/0x5/0xFF for 2 cycles; `done`=1 with pc=2; exactly 4 `issue_valid` cycles in total.
- Jump and wrap:
  - Stimulus: load addr 15=16'h3100, addr 0=16'hF000, addr 1=16'hE00F; start.
  - Required: pc follows 0 (HALT) → `done`, 0xF never appears on `opcode`.
  - Stimulus: reload addr 0=16'hE00F and start again.
  - Required: pc goes 0→15, 0x3 is issued, pc wraps to 0, the JMP repeats, and `issue_valid` pulses every 6 cycles.
- Abort mid-issue:
  - Stimulus: assert `abort` in the first ISSUE cycle.
  - Required: next cycle is IDLE, `opcode`=NOP_OP, `issue_valid`=0, `busy`=0, `pc`=0.
- Load protection:
  - Stimulus: `load_en` with addr 1=16'h7777 while `busy`=1.
  - Required: the fetch of addr 1 returns the original word; no 0x7 opcode appears.
  - Stimulus: the same load in DONE.
  - Required: it takes effect, and the next run issues 0x7/0x7/0x77.
- Restart from DONE with simultaneous load:
  - Stimulus: `start` and `load_en` (addr 0=16'h4001) in the same cycle.
  - Required: the first issued instruction is 0x4/0x0/0x01.

Source files
------------

// File: rtl/risc_sequencer_if.sv
// Purpose: bundles the host load/control port and the core instruction bus of risc_sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; the core takes every issued word, and the sequencer drops host loads while busy.
// Ports (master = host/bench side, slave = sequencer side):
//   load_en/load_addr/load_data : program store write port
//   start/abort                 : run control
//   opcode/operand_1/operand_2  : instruction presented to the core
//   issue_valid/pc/busy/done    : sequencer status
interface risc_sequencer_if;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        abort;
  logic [3:0]  opcode;
  logic [3:0]  operand_1;
  logic [7:0]  operand_2;
  logic        issue_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  modport master (
    output load_en, load_addr, load_data, start, abort,
    input  opcode, operand_1, operand_2, issue_valid, pc, busy, done
  );

  modport slave (
    input  load_en, load_addr, load_data, start, abort,
    output opcode, operand_1, operand_2, issue_valid, pc, busy, done
  );
endinterface

// File: rtl/risc_sequencer.sv
// Purpose: 16-entry program store and sequencer; resolves HALT/JMP itself and feeds other words to the core.
// Latency: start -> first issue 3 cycles; each issued word takes 2+ISSUE_CYCLES cycles; each JMP takes 2 cycles.
// Backpressure: none; load/start are ignored while busy, abort wins over start and load, rst wins over all.
// Ports: clk, rst (synchronous, active-high), bus (risc_sequencer_if.slave) carrying load port,
//        start/abort, core instruction outputs and status (issue_valid, pc, busy, done).
module risc_sequencer #(
  parameter int unsigned ISSUE_CYCLES = 2,
  parameter logic [3:0]  NOP_OP       = 4'h0,
  parameter logic [3:0]  HALT_OP      = 4'hF,
  parameter logic [3:0]  JMP_OP       = 4'hE
) (
  input logic             clk,
  input logic             rst,
  risc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ISSUE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic        mem_we;

  // Program store has no reset: its contents must survive rst.
  logic [15:0] prog_mem [16];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 4'd0;
      cnt_q   <= 4'd0;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
    end
  end

  // mem_we is already clear while abort is high; rst also blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      prog_mem[bus.load_addr] <= bus.load_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    mem_we  = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      pc_d    = 4'd0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // A load in the same cycle as start is written now, so the first fetch sees it.
          mem_we = bus.load_en;
          if (bus.start) begin
            state_d = S_FETCH;
            pc_d    = 4'd0;
          end
        end
        S_FETCH: begin
          ir_d    = prog_mem[pc_q];
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (ir_q[15:12] == HALT_OP) begin
            state_d = S_DONE;
          end else if (ir_q[15:12] == JMP_OP) begin
            pc_d    = ir_q[3:0];
            state_d = S_FETCH;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt_q == 4'd0) begin
            pc_d    = pc_q + 4'd1;  // wraps 15 -> 0
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          pc_d    = 4'd0;
        end
      endcase
    end
  end

  // Outputs depend only on registered state, so no input reaches an output combinationally.
  always_comb begin
    bus.opcode      = NOP_OP;
    bus.operand_1   = 4'd0;
    bus.operand_2   = 8'd0;
    bus.issue_valid = 1'b0;
    bus.pc          = pc_q;
    bus.busy        = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_ISSUE);
    bus.done        = (state_q == S_DONE);
    if (state_q == S_ISSUE) begin
      bus.opcode      = ir_q[15:12];
      bus.operand_1   = ir_q[11:8];
      bus.operand_2   = ir_q[7:0];
      bus.issue_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// Purpose: self-checking bench for risc_sequencer; a program-level model predicts every output cycle.
// Latency: model output for a cycle is produced at the edge that starts it and compared mid-cycle.
// Backpressure: not applicable; the bench drives all inputs directly.
`timescale 1ns/1ps
module tb_risc_sequencer;
  localparam int         IC   = 2;
  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] HALT = 4'hF;
  localparam logic [3:0] JMP  = 4'hE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc_sequencer_if bus();

  risc_sequencer #(.ISSUE_CYCLES(IC), .NOP_OP(NOP), .HALT_OP(HALT), .JMP_OP(JMP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] o1;
    logic [7:0] o2;
    logic       iv;
    logic [3:0] pc;
    logic       busy;
    logic       done;
  } rec_t;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // The model interprets the program one instruction at a time and expands each into the list
  // of cycles it occupies on the outputs.
  logic [15:0] mem [16];
  rec_t        q[$];
  rec_t        cur;
  bit          running = 0, dn = 0, halt_pend = 0, mvalid = 0;
  logic [3:0]  vpc = 4'd0, hpc = 4'd0;

  function automatic rec_t mk(logic [3:0] op, logic [3:0] o1, logic [7:0] o2, logic iv,
                              logic [3:0] pc, logic busy, logic done);
    rec_t r;
    r = '{op: op, o1: o1, o2: o2, iv: iv, pc: pc, busy: busy, done: done};
    return r;
  endfunction

  task automatic gen();
    logic [15:0] w;
    w = mem[vpc];
    q.push_back(mk(NOP, 4'd0, 8'd0, 1'b0, vpc, 1'b1, 1'b0));
    q.push_back(mk(NOP, 4'd0, 8'd0, 1'b0, vpc, 1'b1, 1'b0));
    if (w[15:12] == HALT) begin
      halt_pend = 1;
      hpc = vpc;
    end else if (w[15:12] == JMP) begin
      vpc = w[3:0];
    end else begin
      for (int i = 0; i < IC; i++) q.push_back(mk(w[15:12], w[11:8], w[7:0], 1'b1, vpc, 1'b1, 1'b0));
      vpc = vpc + 4'd1;
    end
  endtask

  task automatic advance();
    if (q.size() == 0) begin
      if (halt_pend) begin
        halt_pend = 0;
        running = 0;
        dn = 1;
      end else begin
        gen();
      end
    end
    if (running) cur = q.pop_front();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete(); running = 0; dn = 0; halt_pend = 0; mvalid = 1;
      end else if (bus.abort) begin
        q.delete(); running = 0; dn = 0; halt_pend = 0;
      end else if (running) begin
        advance();
      end else begin
        if (bus.load_en) mem[bus.load_addr] = bus.load_data;
        if (bus.start) begin
          running = 1; dn = 0; vpc = 4'd0;
          advance();
        end
      end
      if (!running) cur = dn ? mk(NOP, 4'd0, 8'd0, 1'b0, hpc, 1'b0, 1'b1)
                             : mk(NOP, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    end
  end

  // ---------------- compare + monitor ----------------
  int         cyc = 0, iv_cnt = 0, seven_cnt = 0, f_cnt = 0, rise_prev = 0, rise_last = 0;
  logic       prev_iv = 1'b0;
  logic [15:0] seven_word = 16'd0;

  initial begin
    forever begin
      rec_t d;
      @(negedge clk);
      cyc++;
      d = mk(bus.opcode, bus.operand_1, bus.operand_2, bus.issue_valid, bus.pc, bus.busy, bus.done);
      if (mvalid) begin
        checks++;
        if (d !== cur) begin
          errors++;
          $display("FAIL cycle_cmp @%0d: dut op=%h o1=%h o2=%h iv=%b pc=%h busy=%b done=%b, model op=%h o1=%h o2=%h iv=%b pc=%h busy=%b done=%b",
                   cyc, d.op, d.o1, d.o2, d.iv, d.pc, d.busy, d.done,
                   cur.op, cur.o1, cur.o2, cur.iv, cur.pc, cur.busy, cur.done);
        end
      end
      if (bus.issue_valid === 1'b1) begin
        iv_cnt++;
        if (bus.opcode == 4'h7) begin
          seven_cnt++;
          seven_word = {bus.opcode, bus.operand_1, bus.operand_2};
        end
        if (!prev_iv) begin
          rise_prev = rise_last;
          rise_last = cyc;
        end
      end
      if (bus.opcode === HALT) f_cnt++;
      prev_iv = bus.issue_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] dat);
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = dat;
    tick();
    bus.load_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (bus.done !== 1'b1 && n < 200) begin tick(); n++; end
    chk({nm, "_done_reached"}, int'(bus.done), 1);
  endtask

  // Ends in the first ISSUE cycle of the next instruction.
  task automatic wait_rise(input string nm);
    int n = 0;
    while (bus.issue_valid === 1'b1 && n < 100) begin tick(); n++; end
    while (bus.issue_valid !== 1'b1 && n < 100) begin tick(); n++; end
    chk({nm, "_issue_reached"}, int'(bus.issue_valid), 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s_iv, s_seven;
    bus.load_en = 1'b0; bus.load_addr = 4'd0; bus.load_data = 16'd0;
    bus.start = 1'b0; bus.abort = 1'b0;

    // Reset / idle
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_opcode", int'(bus.opcode), int'(NOP));
    chk("idle_status", int'({bus.busy, bus.done, bus.issue_valid}), 0);
    chk("idle_pc", int'(bus.pc), 0);

    for (int i = 0; i < 16; i++) load(4'(i), 16'hF000);

    // Straight-line program
    load(4'd0, 16'h1234); load(4'd1, 16'h25FF); load(4'd2, 16'hF000);
    s_iv = iv_cnt;
    pulse_start();
    tick(); tick();
    chk("sl_first_issue", int'({bus.issue_valid, bus.opcode, bus.operand_1, bus.operand_2}), 'h11234);
    tick();
    chk("sl_first_hold", int'({bus.issue_valid, bus.opcode, bus.operand_1, bus.operand_2}), 'h11234);
    tick();
    chk("sl_gap", int'(bus.issue_valid), 0);
    wait_done("sl");
    chk("sl_done_pc", int'(bus.pc), 2);
    chk("sl_iv_cycles", iv_cnt - s_iv, 4);

    // Jump and wrap
    load(4'd15, 16'h3100); load(4'd0, 16'hF000); load(4'd1, 16'hE00F);
    pulse_start();
    wait_done("jw_halt");
    chk("jw_halt_pc", int'(bus.pc), 0);
    load(4'd0, 16'hE00F);
    pulse_start();
    tick(); tick();
    chk("jw_pc15", int'(bus.pc), 15);
    tick(); tick();
    chk("jw_issue3", int'({bus.issue_valid, bus.opcode, bus.operand_1, bus.operand_2}), 'h13100);
    repeat (18) tick();
    chk("jw_period", rise_last - rise_prev, 6);
    chk("jw_no_f", f_cnt, 0);

    // Abort mid-issue
    wait_rise("ab");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_status", int'({bus.opcode, bus.issue_valid, bus.busy, bus.done}), int'({NOP, 3'b000}));
    chk("ab_pc", int'(bus.pc), 0);

    // Load protection
    load(4'd0, 16'h1234); load(4'd1, 16'h25FF); load(4'd2, 16'hF000);
    s_iv = iv_cnt; s_seven = seven_cnt;
    pulse_start();
    load(4'd1, 16'h7777);
    wait_done("lp");
    chk("lp_no_seven", seven_cnt - s_seven, 0);
    chk("lp_iv_cycles", iv_cnt - s_iv, 4);
    load(4'd1, 16'h7777);
    s_seven = seven_cnt;
    pulse_start();
    wait_done("lp2");
    chk("lp2_seven_cycles", seven_cnt - s_seven, 2);
    chk("lp2_seven_word", int'(seven_word), 'h7777);

    // Restart from DONE with simultaneous load
    bus.start = 1'b1; bus.load_en = 1'b1; bus.load_addr = 4'd0; bus.load_data = 16'h4001;
    tick();
    bus.start = 1'b0; bus.load_en = 1'b0;
    tick(); tick();
    chk("rs_first_issue", int'({bus.issue_valid, bus.opcode, bus.operand_1, bus.operand_2}), 'h14001);

    // Reset mid-issue, store retained
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_status", int'({bus.opcode, bus.operand_1, bus.operand_2, bus.issue_valid, bus.busy, bus.done}), int'({NOP, 15'd0}));
    chk("rst_pc", int'(bus.pc), 0);
    pulse_start();
    tick(); tick();
    chk("rst_retained", int'({bus.issue_valid, bus.opcode, bus.operand_1, bus.operand_2}), 'h14001);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 499) == 0);
      bus.abort     = ($urandom_range(0, 149) == 0);
      bus.start     = ($urandom_range(0, 14) == 0);
      bus.load_en   = ($urandom_range(0, 5) == 0);
      bus.load_addr = 4'($urandom_range(0, 15));
      bus.load_data = 16'($urandom);
      tick();
    end
    rst = 1'b0; bus.abort = 1'b0; bus.start = 1'b0; bus.load_en = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
